// File: rtl/dmem_arbiter_pkg.sv
// Shared types and sizes for the data-memory arbiter.
package dmem_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int DEPTH  = 256;
    localparam int NPORTS = 2;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    typedef logic port_t;

    // One latched memory transaction, captured at the arbitration edge
    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        port_t             port;
    } txn_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of both master ports plus the memory pins.
interface dmem_arbiter_if;
    import dmem_pkg::*;

    logic              m0_req;
    logic              m0_we;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_wdata;
    logic              m0_gnt;
    logic              m0_rvalid;
    logic [DATA_W-1:0] m0_rdata;
    logic              m0_err;

    logic              m1_req;
    logic              m1_we;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_wdata;
    logic              m1_gnt;
    logic              m1_rvalid;
    logic [DATA_W-1:0] m1_rdata;
    logic              m1_err;

    logic              mem_mw;
    logic              mem_mr;
    logic [ADDR_W-1:0] mem_a;
    logic [DATA_W-1:0] mem_wd;
    logic [DATA_W-1:0] mem_rd;

    // Arbiter side
    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        input  m1_req, m1_we, m1_addr, m1_wdata,
        output m0_gnt, m0_rvalid, m0_rdata, m0_err,
        output m1_gnt, m1_rvalid, m1_rdata, m1_err,
        output mem_mw, mem_mr, mem_a, mem_wd,
        input  mem_rd
    );

    // Masters and memory side
    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        output m1_req, m1_we, m1_addr, m1_wdata,
        input  m0_gnt, m0_rvalid, m0_rdata, m0_err,
        input  m1_gnt, m1_rvalid, m1_rdata, m1_err,
        input  mem_mw, mem_mr, mem_a, mem_wd,
        output mem_rd
    );

endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// Combinational 2-way round-robin picker with a per-port mask.
module rr_arb2
    import dmem_pkg::*;
(
    input  logic [1:0] i_req,
    input  logic [1:0] i_mask,
    input  port_t      i_ptr,
    output logic       o_valid,
    output port_t      o_winner
);

    logic [1:0] w_elig;

    // Pointer only matters when both ports are eligible
    assign w_elig   = i_req & ~i_mask;
    assign o_valid  = |w_elig;
    assign o_winner = (&w_elig) ? i_ptr : w_elig[1];

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one single-ported data memory between the CPU (port 0) and a
// DMA/debug master (port 1); one access per cycle, registered responses.
module dmem_arbiter
    import dmem_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    dmem_arbiter_if.slave  bus
);

    logic [NPORTS-1:0]             w_req;
    logic [NPORTS-1:0]             w_we;
    logic [NPORTS-1:0][ADDR_W-1:0] w_addr;
    logic [NPORTS-1:0][DATA_W-1:0] w_wdata;

    state_t r_state, w_state_nxt;
    txn_t   r_txn;
    port_t  r_ptr;

    logic [NPORTS-1:0] w_mask;
    logic              w_arb_valid;
    port_t             w_winner;
    logic              w_access;
    logic              w_in_range;
    logic [NPORTS-1:0] w_hit;

    logic [NPORTS-1:0]             r_rvalid;
    logic [NPORTS-1:0]             r_err;
    logic [NPORTS-1:0][DATA_W-1:0] r_rdata;

    assign w_req   = {bus.m1_req,   bus.m0_req};
    assign w_we    = {bus.m1_we,    bus.m0_we};
    assign w_addr  = {bus.m1_addr,  bus.m0_addr};
    assign w_wdata = {bus.m1_wdata, bus.m0_wdata};

    // Mask the port whose access is ending so it can drop req after gnt
    always_comb begin
        w_mask = '0;
        if (r_state == ACCESS) w_mask[r_txn.port] = 1'b1;
    end

    rr_arb2 u_arb (
        .i_req    (w_req),
        .i_mask   (w_mask),
        .i_ptr    (r_ptr),
        .o_valid  (w_arb_valid),
        .o_winner (w_winner)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next state and memory-side outputs; the latched transaction owns ACCESS
    always_comb begin
        w_state_nxt = IDLE;
        w_access    = 1'b0;
        w_in_range  = 1'b0;
        w_hit       = '0;
        if (w_arb_valid) w_state_nxt = ACCESS;
        if (r_state == ACCESS) begin
            w_access   = 1'b1;
            w_in_range = (r_txn.addr < ADDR_W'(DEPTH));
            w_hit[r_txn.port] = 1'b1;
        end
    end

    assign bus.mem_mw = w_access &  r_txn.we & w_in_range;
    assign bus.mem_mr = w_access & ~r_txn.we & w_in_range;
    assign bus.mem_a  = w_access ? r_txn.addr  : '0;
    assign bus.mem_wd = w_access ? r_txn.wdata : '0;

    // Request latch and round-robin pointer, updated on every arbitration win
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_txn <= '0;
            r_ptr <= 1'b0;
        end else if (w_arb_valid) begin
            r_txn.we    <= w_we[w_winner];
            r_txn.addr  <= w_addr[w_winner];
            r_txn.wdata <= w_wdata[w_winner];
            r_txn.port  <= w_winner;
            r_ptr       <= ~w_winner;
        end
    end

    // Per-port response registers: one-cycle rvalid/err, rdata held
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rvalid <= '0;
            r_err    <= '0;
            r_rdata  <= '0;
        end else begin
            for (int p = 0; p < NPORTS; p++) begin
                r_rvalid[p] <= w_hit[p];
                r_err[p]    <= w_hit[p] & ~w_in_range;
                if (w_hit[p]) begin
                    if (!w_in_range)    r_rdata[p] <= '0;
                    else if (!r_txn.we) r_rdata[p] <= bus.mem_rd;
                end
            end
        end
    end

    assign bus.m0_gnt    = w_hit[0];
    assign bus.m1_gnt    = w_hit[1];
    assign bus.m0_rvalid = r_rvalid[0];
    assign bus.m1_rvalid = r_rvalid[1];
    assign bus.m0_err    = r_err[0];
    assign bus.m1_err    = r_err[1];
    assign bus.m0_rdata  = r_rdata[0];
    assign bus.m1_rdata  = r_rdata[1];

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a transaction-level reference model.
module tb_dmem_arbiter;
    import dmem_pkg::*;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    dmem_arbiter_if bus();

    dmem_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Physical memory attached to the arbiter's pins
    logic [31:0] mem [0:255] = '{default: '0};
    always @(posedge clk) if (bus.mem_mw) mem[bus.mem_a[7:0]] <= bus.mem_wd;
    assign bus.mem_rd = mem[bus.mem_a[7:0]];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: the transaction in flight, the pointer, responses
    logic        m_cur_v;
    logic        m_cur_port;
    logic        m_cur_we;
    logic [31:0] m_cur_addr;
    logic [31:0] m_cur_wd;
    logic        m_ptr;
    logic        m_rvalid [2];
    logic        m_err    [2];
    logic [31:0] m_rdata  [2];
    logic [31:0] ref_mem  [0:255] = '{default: '0};

    always @(posedge clk or negedge rst_n) begin : mdl
        logic e0, e1, win;
        if (!rst_n) begin
            m_cur_v <= 1'b0;
            m_ptr   <= 1'b0;
            for (int p = 0; p < 2; p++) begin
                m_rvalid[p] <= 1'b0;
                m_err[p]    <= 1'b0;
                m_rdata[p]  <= '0;
            end
        end else begin
            for (int p = 0; p < 2; p++) begin
                m_rvalid[p] <= m_cur_v && (m_cur_port == p[0]);
                m_err[p]    <= m_cur_v && (m_cur_port == p[0]) && (m_cur_addr >= 256);
            end
            if (m_cur_v) begin
                if (m_cur_addr >= 256)  m_rdata[m_cur_port] <= '0;
                else if (m_cur_we)      ref_mem[m_cur_addr[7:0]] <= m_cur_wd;
                else                    m_rdata[m_cur_port] <= ref_mem[m_cur_addr[7:0]];
            end
            e0  = bus.m0_req && !(m_cur_v && m_cur_port == 1'b0);
            e1  = bus.m1_req && !(m_cur_v && m_cur_port == 1'b1);
            win = (e0 && e1) ? m_ptr : e1;
            m_cur_v <= e0 || e1;
            if (e0 || e1) begin
                m_cur_port <= win;
                m_cur_we   <= win ? bus.m1_we    : bus.m0_we;
                m_cur_addr <= win ? bus.m1_addr  : bus.m0_addr;
                m_cur_wd   <= win ? bus.m1_wdata : bus.m0_wdata;
                m_ptr      <= ~win;
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin : cmp
        logic inr, e_mw, e_mr;
        inr  = m_cur_addr < 256;
        e_mw = m_cur_v &&  m_cur_we && inr;
        e_mr = m_cur_v && !m_cur_we && inr;
        chk("gnt0",   bus.m0_gnt, m_cur_v && m_cur_port == 1'b0);
        chk("gnt1",   bus.m1_gnt, m_cur_v && m_cur_port == 1'b1);
        chk("mem_mw", bus.mem_mw, e_mw);
        chk("mem_mr", bus.mem_mr, e_mr);
        if (!m_cur_v || e_mw || e_mr) chk("mem_a", bus.mem_a, m_cur_v ? m_cur_addr : 32'h0);
        if (!m_cur_v || e_mw)         chk("mem_wd", bus.mem_wd, m_cur_v ? m_cur_wd : 32'h0);
        chk("rvalid0", bus.m0_rvalid, m_rvalid[0]);
        chk("rvalid1", bus.m1_rvalid, m_rvalid[1]);
        chk("err0",    bus.m0_err,    m_err[0]);
        chk("err1",    bus.m1_err,    m_err[1]);
        chk("rdata0",  bus.m0_rdata,  m_rdata[0]);
        chk("rdata1",  bus.m1_rdata,  m_rdata[1]);
    end

    // Raise req on one port, wait (bounded) for its grant, then drop req.
    // Returns positioned 2 time units into the grant cycle.
    task automatic xfer(input int p, input logic we, input logic [31:0] addr, input logic [31:0] wd);
        bit ok;
        ok = 0;
        if (p == 0) begin
            bus.m0_we = we; bus.m0_addr = addr; bus.m0_wdata = wd; bus.m0_req = 1'b1;
        end else begin
            bus.m1_we = we; bus.m1_addr = addr; bus.m1_wdata = wd; bus.m1_req = 1'b1;
        end
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #2;
            if ((p == 0) ? bus.m0_gnt : bus.m1_gnt) begin
                ok = 1;
                break;
            end
        end
        bus.m0_req = 1'b0;
        bus.m1_req = 1'b0;
        if (!ok) chk("gnt_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int g0, g1, prev, tot, g;
        logic prevmr;
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.m0_req = 0; bus.m0_we = 0; bus.m0_addr = 0; bus.m0_wdata = 0;
        bus.m1_req = 0; bus.m1_we = 0; bus.m1_addr = 0; bus.m1_wdata = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_gnt0",   bus.m0_gnt, 0);
        chk("rst_rvalid", {bus.m0_rvalid, bus.m1_rvalid}, 0);
        chk("rst_rdata0", bus.m0_rdata, 0);
        chk("rst_mem",    {bus.mem_mw, bus.mem_mr}, 0);
        chk("rst_mem_a",  bus.mem_a, 0);
        #1 rst_n = 1'b1;

        // Simultaneous reads right after reset: port 0 first, then port 1
        @(posedge clk); #2;
        bus.m0_we = 0; bus.m0_addr = 5; bus.m0_req = 1;
        bus.m1_we = 0; bus.m1_addr = 7; bus.m1_req = 1;
        @(posedge clk); #2;
        chk("t2_gnt0_first", {bus.m1_gnt, bus.m0_gnt}, 2'b01);
        bus.m0_req = 0;
        @(posedge clk); #2;
        chk("t2_gnt1_next",  {bus.m1_gnt, bus.m0_gnt}, 2'b10);
        chk("t2_rvalid0",    bus.m0_rvalid, 1);
        bus.m1_req = 0;
        @(posedge clk); #2;
        chk("t2_rvalid1",    {bus.m1_rvalid, bus.m0_rvalid}, 2'b10);

        // Write then read back through port 0
        xfer(0, 1'b1, 32'd5, 32'hDEADBEEF);
        chk("t1_mw",  bus.mem_mw, 1);
        chk("t1_a",   bus.mem_a, 5);
        chk("t1_wd",  bus.mem_wd, 32'hDEADBEEF);
        xfer(0, 1'b0, 32'd5, 32'd0);
        chk("t1_mr",  bus.mem_mr, 1);
        @(posedge clk); #2;
        chk("t1_rvalid0", bus.m0_rvalid, 1);
        chk("t1_rdata0",  bus.m0_rdata, 32'hDEADBEEF);
        chk("t1_err0",    bus.m0_err, 0);

        // Both ports held busy for 8 transactions: strict alternation
        bus.m0_we = 1; bus.m0_addr = 20; bus.m0_wdata = 32'h11; bus.m0_req = 1;
        bus.m1_we = 0; bus.m1_addr = 5;  bus.m1_req = 1;
        g0 = 0; g1 = 0; prev = -1; tot = 0;
        for (int c = 0; c < 20 && tot < 8; c++) begin
            @(posedge clk); #2;
            chk("t3_one_gnt", bus.m0_gnt ^ bus.m1_gnt, 1);
            chk("t3_busy",    bus.mem_mw | bus.mem_mr, 1);
            if (prev >= 0) chk("t3_alternate", bus.m1_gnt, (prev == 0) ? 1 : 0);
            prev = bus.m1_gnt ? 1 : 0;
            g0 += int'(bus.m0_gnt);
            g1 += int'(bus.m1_gnt);
            tot = g0 + g1;
        end
        bus.m0_req = 0; bus.m1_req = 0;
        chk("t3_g0", g0, 4);
        chk("t3_g1", g1, 4);
        repeat (2) @(posedge clk); #2;

        // Out-of-range read on port 1
        xfer(1, 1'b0, 32'd256, 32'd0);
        chk("t4_no_mr", {bus.mem_mw, bus.mem_mr}, 0);
        @(posedge clk); #2;
        chk("t4_rvalid_err", {bus.m1_rvalid, bus.m1_err}, 2'b11);
        chk("t4_rdata1",     bus.m1_rdata, 0);

        // Reset during a write's ACCESS cycle
        @(posedge clk); #2;
        xfer(0, 1'b1, 32'd10, 32'hCAFE);
        rst_n = 1'b0;
        #1;
        chk("t5_gnt0",   bus.m0_gnt, 0);
        chk("t5_mw",     bus.mem_mw, 0);
        chk("t5_a",      bus.mem_a, 0);
        chk("t5_wd",     bus.mem_wd, 0);
        chk("t5_rdata0", bus.m0_rdata, 0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #2;
        chk("t5_idle",     {bus.m1_gnt, bus.m0_gnt}, 0);
        chk("t5_no_rvalid", bus.m0_rvalid, 0);
        xfer(1, 1'b0, 32'd5, 32'd0);
        @(posedge clk); #2;
        chk("t5_rvalid1", bus.m1_rvalid, 1);
        chk("t5_rdata1",  bus.m1_rdata, 32'hDEADBEEF);

        // Port 0 alone, holding req: grant every other cycle
        bus.m0_we = 0; bus.m0_addr = 5; bus.m0_req = 1;
        g = 0; prevmr = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #2;
            g += int'(bus.m0_gnt);
            if (prevmr) chk("t6_mr_gap", bus.mem_mr, 0);
            prevmr = bus.mem_mr;
        end
        bus.m0_req = 0;
        chk("t6_g0", g, 4);
        repeat (3) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
